poly_bank_io: RTL and testbench
===============================

// Module: poly_bank_io
// PURPOSE
//  Streaming load/unload engine for the banked polynomial memory of the NWC/NTT top.
//  Replaces backdoor preload and readout of memory_array with a valid/ready coefficient stream.
//  Coefficient i maps to bank i%BN, row i/BN. LANES coefficients move per beat.
//  Range-checks input coefficients against modulus.
//  Sits between the host stream and the bank write/read ports of memory_rtl.
// PARAMETERS
//  D_WIDTH  17        coefficient width (holds values < 65537)
//  BN       16        number of memory banks
//  MA       256       rows per bank (degree = BN*MA)
//  LANES    4         coefficients per stream beat; BN % LANES == 0
//  ADDR_W   $clog2(MA) row address width
// PORTS
//  clk           in   1               clock, rising edge
//  rst           in   1               asynchronous reset, active-high
//  modulus       in   D_WIDTH         range-check bound; stable while busy
//  start_load    in   1               pulse: begin load of BN*MA coefficients
//  start_unload  in   1               pulse: begin readout of BN*MA coefficients
//  in_valid      in   1               input beat valid
//  in_ready      out  1               input beat accepted when in_valid&in_ready
//  in_data       in   LANES*D_WIDTH   lane l = bits [l*D_WIDTH +: D_WIDTH]
//  wr_en         out  BN              per-bank write strobe
//  wr_addr       out  ADDR_W          row address for all banks
//  wr_data       out  BN*D_WIDTH      bank b data = bits [b*D_WIDTH +: D_WIDTH]
//  rd_en         out  1               read request for row rd_addr, all banks
//  rd_addr       out  ADDR_W          read row
//  rd_data       in   BN*D_WIDTH      read data, valid exactly 1 cycle after rd_en
//  out_valid     out  1               output beat valid
//  out_ready     in   1               sink accepts when out_valid&out_ready
//  out_data      out  LANES*D_WIDTH   same lane packing as in_data
//  out_last      out  1               high on the final beat of an unload
//  busy          out  1               high in any state other than IDLE
//  done          out  1               1-cycle pulse when a load or unload completes
//  err_range     out  1               sticky: some loaded coefficient >= modulus
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; row/beat counters 0; row buffer cleared.
//  Reset mid-operation aborts immediately: no further writes, no further beats.
//  FSM states: IDLE, LOAD, RD_REQ, RD_WAIT, SEND, FIN.
//  IDLE:
//   - start_load -> LOAD; clear err_range.
//   - else start_unload -> RD_REQ.
//   - Both in the same cycle: load wins, unload dropped.
//   - Starts outside IDLE are ignored.
//  LOAD:
//   - in_ready=1.
//   - Accepted beat j (0..BN/LANES-1) of row r registers, on the next cycle:
//     wr_en bits [j*LANES +: LANES]=1, wr_addr=r, lane data in those bank slots.
//   - Write latency: 1 cycle. Other wr_data slots = 0.
//   - Beat counter wraps at BN/LANES and increments row.
//   - After the last beat of row MA-1 is accepted -> FIN, with in_ready=0 from that cycle.
//  Range check: any accepted lane >= modulus sets err_range.
//   - Data is written unchanged.
//   - err_range holds until the next start_load or rst.
//  RD_REQ: rd_en=1 for one cycle, rd_addr=row -> RD_WAIT.
//  RD_WAIT: capture rd_data into row buffer -> SEND.
//  SEND:
//   - out_valid=1, out_data = buffer lanes of beat j.
//   - out_data is held stable while out_ready=0.
//   - On handshake, j++. At the last beat of the row: row++ -> RD_REQ, or -> FIN if row was MA-1.
//   - out_last=1 only at beat BN/LANES-1 of row MA-1.
//  FIN: done=1 for one cycle -> IDLE. busy=0 in IDLE only.
//  Counters are ADDR_W and $clog2(BN/LANES) bits and wrap cleanly at MA-1.
// TESTING
//  T1: reset mid-LOAD (after 5 beats) -> wr_en=0 within the reset assertion; busy=0; in_ready=0.
//  T2: load 0..4095 (BN=16, LANES=4, modulus=65537)
//      -> bank b row k holds 16k+b; done one cycle after final write; err_range=0.
//  T3: load with coefficient 65537 at index 37, then 0 elsewhere
//      -> err_range=1 after the beat; bank 5 row 2 = 65537; cleared by next start_load.
//  T4: unload after T2 with random out_ready stalls
//      -> beats in order 0..4095; data stable under stall; out_last only on the 1024th beat.
//  T5: start_load and start_unload asserted together in IDLE -> LOAD entered, in_ready=1, no rd_en.
//  T6: start_unload during LOAD -> ignored; load completes normally; single done pulse.

Source files
------------

// File: rtl/poly_bank_io_if.sv
// Stream and bank-port bundle for poly_bank_io: host coefficient streams in/out,
// plus the row-wide write and read ports of the banked memory.
interface poly_bank_io_if #(
  parameter int D_WIDTH = 17,
  parameter int BN      = 16,
  parameter int LANES   = 4,
  parameter int ADDR_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic [LANES*D_WIDTH-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [LANES*D_WIDTH-1:0] out_data;
  logic                     out_last;
  logic [BN-1:0]            wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [BN*D_WIDTH-1:0]    wr_data;
  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic [BN*D_WIDTH-1:0]    rd_data;

  modport slave (
    input  in_valid, in_data, out_ready, rd_data,
    output in_ready, out_valid, out_data, out_last,
           wr_en, wr_addr, wr_data, rd_en, rd_addr
  );

  modport master (
    output in_valid, in_data, out_ready, rd_data,
    input  in_ready, out_valid, out_data, out_last,
           wr_en, wr_addr, wr_data, rd_en, rd_addr
  );
endinterface

// File: rtl/poly_bank_io.sv
// Streaming load/unload engine for the banked polynomial memory.
// Coefficient i lives in bank i%BN, row i/BN; LANES coefficients per beat.
module poly_lane_chk #(
  parameter int D_WIDTH = 17
) (
  input  logic [D_WIDTH-1:0] coef,
  input  logic [D_WIDTH-1:0] modulus,
  output logic               over
);
  assign over = (coef >= modulus);
endmodule

module poly_bank_io #(
  parameter int D_WIDTH = 17,
  parameter int BN      = 16,
  parameter int MA      = 256,
  parameter int LANES   = 4,
  parameter int ADDR_W  = $clog2(MA)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] modulus,
  input  logic               start_load,
  input  logic               start_unload,
  output logic               busy,
  output logic               done,
  output logic               err_range,
  poly_bank_io_if.slave      bus
);
  localparam int BPR = BN / LANES;
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [BW-1:0]     BEAT_LAST = BW'(BPR - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(MA - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, SEND, FIN} state_t;

  typedef logic [BPR-1:0][LANES-1:0][D_WIDTH-1:0] row_t;

  state_t state, nxt;
  logic [ADDR_W-1:0] row;
  logic [BW-1:0]     beat;
  logic [LANES-1:0][D_WIDTH-1:0] in_lanes;
  logic [LANES-1:0]  lane_over;
  row_t              row_buf, wr_row;
  logic [BPR-1:0][LANES-1:0] wr_mask;
  logic acc, hs, last_beat, last_row, kick;

  assign in_lanes  = bus.in_data;
  assign acc       = (state == LOAD) && bus.in_valid;
  assign hs        = (state == SEND) && bus.out_ready;
  assign last_beat = (beat == BEAT_LAST);
  assign last_row  = (row == ROW_LAST);
  assign kick      = (state == IDLE) && (start_load || start_unload);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    poly_lane_chk #(.D_WIDTH(D_WIDTH)) u_chk (
      .coef(in_lanes[l]), .modulus(modulus), .over(lane_over[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt           = state;
    busy          = (state != IDLE);
    done          = (state == FIN);
    bus.in_ready  = (state == LOAD);
    bus.rd_en     = (state == RD_REQ);
    bus.rd_addr   = row;
    bus.out_valid = (state == SEND);
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    unique case (state)
      IDLE:    if (start_load) nxt = LOAD;
               else if (start_unload) nxt = RD_REQ;
      LOAD:    if (acc && last_beat && last_row) nxt = FIN;
      RD_REQ:  nxt = RD_WAIT;
      RD_WAIT: nxt = SEND;
      SEND: begin
        bus.out_data = row_buf[beat];
        bus.out_last = last_beat && last_row;
        if (hs && last_beat) nxt = last_row ? FIN : RD_REQ;
      end
      FIN:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // One beat of counters serves both directions; start from IDLE rewinds to coefficient 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row  <= '0;
      beat <= '0;
    end else if (kick) begin
      row  <= '0;
      beat <= '0;
    end else if (acc || hs) begin
      beat <= last_beat ? '0 : beat + 1'b1;
      if (last_beat) row <= last_row ? '0 : row + 1'b1;
    end
  end

  always_comb begin
    wr_row        = '0;
    wr_mask       = '0;
    wr_row[beat]  = in_lanes;
    wr_mask[beat] = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_en   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
    end else if (acc) begin
      bus.wr_en   <= wr_mask;
      bus.wr_addr <= row;
      bus.wr_data <= wr_row;
    end else begin
      bus.wr_en   <= '0;
      bus.wr_data <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    row_buf <= '0;
    else if (state == RD_WAIT)  row_buf <= bus.rd_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        err_range <= 1'b0;
    else if (state == IDLE && start_load) err_range <= 1'b0;
    else if (acc && |lane_over)     err_range <= 1'b1;
  end
endmodule

// File: tb/tb_poly_bank_io.sv
// Bench for poly_bank_io: memory model on the bank ports, coefficient-index reference
// array, table-driven range-check vectors and randomized load/unload rounds.
module tb_poly_bank_io;
  localparam int D = 17, BN = 16, MA = 256, L = 4, AW = 8;
  localparam int N = BN * MA, NB = N / L;

  logic clk = 1'b0, rst = 1'b0;
  logic [D-1:0] modulus = '0;
  logic start_load = 1'b0, start_unload = 1'b0;
  logic busy, done, err_range;

  poly_bank_io_if #(.D_WIDTH(D), .BN(BN), .LANES(L), .ADDR_W(AW)) bus();

  poly_bank_io #(.D_WIDTH(D), .BN(BN), .MA(MA), .LANES(L), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .modulus(modulus), .start_load(start_load),
    .start_unload(start_unload), .busy(busy), .done(done), .err_range(err_range),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [D-1:0] mem [BN][MA];
  logic [D-1:0] coef [N];
  int ncmp = 0, nfail = 0, rd_cnt = 0, done_cnt = 0;

  always @(posedge clk) begin
    for (int b = 0; b < BN; b++)
      if (bus.wr_en[b]) mem[b][bus.wr_addr] <= bus.wr_data[b*D +: D];
    if (bus.rd_en)
      for (int b = 0; b < BN; b++) bus.rd_data[b*D +: D] <= mem[b][bus.rd_addr];
  end

  always @(negedge clk) begin
    if (bus.rd_en) rd_cnt++;
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    ncmp++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [L*D-1:0] beat_of(input int n);
    logic [L*D-1:0] r;
    for (int l = 0; l < L; l++) r[l*D +: D] = coef[n*L + l];
    return r;
  endfunction

  task automatic chk_mem(input string name);
    int bad = 0;
    for (int i = 0; i < N; i++) if (mem[i % BN][i / BN] !== coef[i]) bad++;
    chk(name, bad, 0);
  endtask

  task automatic do_load(input logic [D-1:0] mod, input bit both, input int poke);
    int n = 0, cyc = 0;
    bit acc, poked = 0;
    @(negedge clk);
    modulus = mod; start_load = 1; start_unload = both;
    rd_cnt = 0; done_cnt = 0;
    @(negedge clk);
    start_load = 0; start_unload = 0;
    chk("load_in_ready", bus.in_ready, 1);
    chk("load_err_cleared", err_range, 0);
    while (n < NB && cyc < 20000) begin
      start_unload = (poke >= 0 && n == poke && !poked);
      if (start_unload) poked = 1;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_data  = beat_of(n);
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc) n++;
      cyc++;
    end
    bus.in_valid = 0; start_unload = 0;
    if (n < NB) chk("load_timeout", n, NB);
    chk("load_done_after_final_write", done, 1);
    chk("load_final_wr_en", (bus.wr_en != 0), 1);
    chk("load_in_ready_fin", bus.in_ready, 0);
    @(negedge clk);
    chk("load_idle", busy, 0);
    chk("load_single_done", done_cnt, 1);
    chk("load_no_rd_en", rd_cnt, 0);
  endtask

  task automatic do_unload();
    int n = 0, cyc = 0, data_bad = 0, last_bad = 0, stall_bad = 0;
    bit stalled = 0, hs;
    logic [L*D-1:0] hold = '0;
    @(negedge clk);
    start_unload = 1;
    @(negedge clk);
    start_unload = 0;
    chk("unload_busy", busy, 1);
    while (n < NB && cyc < 40000) begin
      bus.out_ready = ($urandom_range(0, 2) != 0);
      if (stalled && (!bus.out_valid || bus.out_data !== hold)) stall_bad++;
      hs = 0;
      if (bus.out_valid) begin
        if (bus.out_data !== beat_of(n)) data_bad++;
        if (bus.out_last !== (n == NB - 1)) last_bad++;
        hs = bus.out_ready;
        stalled = !bus.out_ready;
        hold = bus.out_data;
      end else begin
        stalled = 0;
        if (bus.out_last) last_bad++;
      end
      @(negedge clk);
      if (hs) n++;
      cyc++;
    end
    bus.out_ready = 0;
    if (n < NB) chk("unload_timeout", n, NB);
    chk("unload_data", data_bad, 0);
    chk("unload_last", last_bad, 0);
    chk("unload_stall_stable", stall_bad, 0);
    chk("unload_done", done, 1);
    @(negedge clk);
    chk("unload_idle", busy, 0);
  endtask

  typedef struct {
    int idx; int val; int mod; int exp_bank; int exp_row; bit exp_err;
  } vec_t;

  initial begin
    vec_t vecs[4];
    bit ee;
    int na;
    vecs[0] = '{idx: 37,   val: 65537, mod: 65537, exp_bank: 5,  exp_row: 2,   exp_err: 1};
    vecs[1] = '{idx: 4095, val: 65536, mod: 65537, exp_bank: 15, exp_row: 255, exp_err: 0};
    vecs[2] = '{idx: 0,    val: 100,   mod: 100,   exp_bank: 0,  exp_row: 0,   exp_err: 1};
    vecs[3] = '{idx: 1000, val: 99,    mod: 100,   exp_bank: 8,  exp_row: 62,  exp_err: 0};

    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_range, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    rst = 0;

    // reset in the middle of a load
    for (int i = 0; i < N; i++) coef[i] = D'(i);
    @(negedge clk);
    modulus = D'(65537); start_load = 1;
    @(negedge clk);
    start_load = 0;
    na = 0;
    for (int c = 0; c < 50 && na < 5; c++) begin
      bus.in_valid = 1; bus.in_data = beat_of(na);
      if (bus.in_ready) na++;
      @(negedge clk);
    end
    chk("t1_beats", na, 5);
    chk("t1_wr_en_active", (bus.wr_en != 0), 1);
    #2 rst = 1;
    #1;
    chk("t1_wr_en_rst", bus.wr_en, 0);
    chk("t1_busy_rst", busy, 0);
    chk("t1_in_ready_rst", bus.in_ready, 0);
    bus.in_valid = 0;
    @(negedge clk) rst = 0;

    // 0..4095 ramp: both starts together, and an ignored start_unload mid-load
    do_load(D'(65537), 1'b1, 300);
    chk("t2_err", err_range, 0);
    chk_mem("t2_mem");
    do_unload();

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < N; i++) coef[i] = '0;
      coef[vecs[v].idx] = D'(vecs[v].val);
      do_load(D'(vecs[v].mod), 1'b0, -1);
      chk($sformatf("vec%0d_err", v), err_range, vecs[v].exp_err);
      chk($sformatf("vec%0d_mem", v), mem[vecs[v].exp_bank][vecs[v].exp_row], vecs[v].val);
    end

    for (int r = 0; r < 2; r++) begin
      int m;
      m = $urandom_range(1000, 65537);
      ee = 0;
      for (int i = 0; i < N; i++) begin
        if (r == 1 && $urandom_range(0, 1999) == 0) coef[i] = D'($urandom_range(m, 131071));
        else coef[i] = D'($urandom_range(0, m - 1));
        if (int'(coef[i]) >= m) ee = 1;
      end
      do_load(D'(m), 1'b0, -1);
      chk($sformatf("rnd%0d_err", r), err_range, ee);
      chk_mem($sformatf("rnd%0d_mem", r));
      do_unload();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
